activation_stage: RTL



---
 rtl/act_pkg.sv | 23 ++
 rtl/activation_stage_lane_delay.sv | 60 ++++++
 rtl/activation_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared types and helpers for the systolic-array activation stage.
// Lane count, accumulator width and int8 saturation live here.
package act_pkg;

    localparam int LANES = 8;
    localparam int ACC_W = 18;

    typedef logic signed [15:0]      psum_t;
    typedef logic signed [7:0]       act_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Clamp a post-shift accumulator into the int8 range.
    function automatic act_t saturate(input acc_t v);
        if (v > 127) begin
            return 8'sh7F;
        end else if (v < -128) begin
            return -8'sh80;
        end else begin
            return act_t'(v[7:0]);
        end
    endfunction

endpackage

// File: rtl/activation_stage_lane_delay.sv
// Per-lane deskew shift register carrying data and valid together.
// DEPTH of zero degenerates to a plain wire.
module lane_delay #(
    parameter int DEPTH = 0,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         busy
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ n_rst;
            assign out_data  = in_data;
            assign out_valid = in_valid;
            assign busy      = 1'b0;
        end else begin : g_reg
            logic [W-1:0]     data_q [DEPTH];
            logic [W-1:0]     data_d [DEPTH];
            logic [DEPTH-1:0] valid_q;
            logic [DEPTH-1:0] valid_d;

            // Shift the whole chain by one slot each cycle.
            always_comb begin
                data_d[0]  = in_data;
                valid_d[0] = in_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    data_d[i]  = data_q[i-1];
                    valid_d[i] = valid_q[i-1];
                end
            end

            // Chain registers; reset flushes every in-flight valid.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    valid_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q <= valid_d;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= data_d[i];
                    end
                end
            end

            assign out_data  = data_q[DEPTH-1];
            assign out_valid = valid_q[DEPTH-1];
            assign busy      = |valid_q;
        end
    endgenerate

endmodule

// File: rtl/activation_stage.sv
// Output stage of the systolic array: deskew, bias, ReLU,
// requantize and saturate each column into one int8 row per cycle.
module activation_stage
    import act_pkg::*;
#(
    parameter int LANES = 8,
    parameter int ROWS  = 8,
    parameter int SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  bias_load,
    input  logic [8*LANES-1:0]    bias_data,
    input  logic                  relu_en,
    input  logic                  clear_err,
    input  logic [16*LANES-1:0]   array_out,
    input  logic [LANES-1:0]      array_out_valid,
    output logic [8*LANES-1:0]    activations,
    output logic                  activations_valid,
    output logic                  tile_done,
    output logic                  stage_busy,
    output logic                  skew_err,
    output logic                  cfg_err
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    psum_t            dsk_data [LANES];
    logic [LANES-1:0] dsk_valid;
    logic [LANES-1:0] dsk_busy;
    logic [LANES-1:0] mismatch;
    logic             aligned;
    logic             skew_now;

    logic [8*LANES-1:0] bias_q, bias_d;
    acc_t               acc_q [LANES];
    acc_t               acc_d [LANES];
    acc_t               relu_v [LANES];
    logic               s1_valid_q, s1_valid_d;
    logic [8*LANES-1:0] act_q, act_d;
    logic               act_valid_q, act_valid_d;
    logic               tile_done_q, tile_done_d;
    logic [RW-1:0]      row_q, row_d;
    logic               skew_err_q, skew_err_d;
    logic               cfg_err_q, cfg_err_d;

    // Column c waits LANES-1-c cycles so all columns of a row line up.
    for (genvar c = 0; c < LANES; c++) begin : g_lane
        lane_delay #(
            .DEPTH(LANES - 1 - c),
            .W    (16)
        ) u_delay (
            .clk      (clk),
            .n_rst    (n_rst),
            .in_data  (array_out[16*c +: 16]),
            .in_valid (array_out_valid[c]),
            .out_data (dsk_data[c]),
            .out_valid(dsk_valid[c]),
            .busy     (dsk_busy[c])
        );
    end

    assign aligned    = dsk_valid[LANES-1];
    assign mismatch   = dsk_valid ^ {LANES{aligned}};
    assign skew_now   = |mismatch;
    assign stage_busy = (|dsk_busy) | s1_valid_q | act_valid_q;

    // Bias capture is refused while rows are in flight.
    always_comb begin
        bias_d    = (bias_load && !stage_busy) ? bias_data : bias_q;
        cfg_err_d = (bias_load && stage_busy) | (cfg_err_q & ~clear_err);
        skew_err_d = skew_now | (skew_err_q & ~clear_err);
    end

    // Stage 1: widen sum and scaled bias; misaligned lanes forced to 0.
    always_comb begin
        s1_valid_d = aligned;
        for (int c = 0; c < LANES; c++) begin
            if (mismatch[c]) begin
                acc_d[c] = '0;
            end else begin
                acc_d[c] = acc_t'(dsk_data[c])
                         + (acc_t'(act_t'(bias_q[8*c +: 8])) <<< SHIFT);
            end
        end
    end

    // ReLU clamps negative accumulators before the shift.
    always_comb begin
        for (int c = 0; c < LANES; c++) begin
            relu_v[c] = (relu_en && acc_q[c][ACC_W-1]) ? '0 : acc_q[c];
        end
    end

    // Stage 2: requantize, saturate, and track the row within the tile.
    always_comb begin
        act_d       = act_q;
        act_valid_d = s1_valid_q;
        tile_done_d = 1'b0;
        row_d       = row_q;
        if (s1_valid_q) begin
            for (int c = 0; c < LANES; c++) begin
                act_d[8*c +: 8] = saturate(relu_v[c] >>> SHIFT);
            end
            tile_done_d = (row_q == LAST_ROW);
            row_d       = tile_done_d ? '0 : row_q + 1'b1;
        end
    end

    // All pipeline, bias and error state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bias_q      <= '0;
            s1_valid_q  <= 1'b0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
            tile_done_q <= 1'b0;
            row_q       <= '0;
            skew_err_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int c = 0; c < LANES; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            bias_q      <= bias_d;
            s1_valid_q  <= s1_valid_d;
            act_q       <= act_d;
            act_valid_q <= act_valid_d;
            tile_done_q <= tile_done_d;
            row_q       <= row_d;
            skew_err_q  <= skew_err_d;
            cfg_err_q   <= cfg_err_d;
            for (int c = 0; c < LANES; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign activations       = act_q;
    assign activations_valid = act_valid_q;
    assign tile_done         = tile_done_q;
    assign skew_err          = skew_err_q;
    assign cfg_err           = cfg_err_q;

endmodule
